// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
// Round-robin arbiter and sequencer that gives four cores access to one
// single-ported shared data memory. Each transaction goes IDLE -> ACCESS ->
// DONE. A core can ask to keep ownership for a limited number of back-to-back
// transactions, for example to do a read-modify-write.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_read/write    per-core request bits; write wins if both are set
//   req_lock          per-core lock hint, sampled at the end of a transaction
//   req_addr/wdata    packed per-core 8-bit address / write data (core i at [8i+7:8i])
//   resp_rdata        registered read data for the last completed read
//   resp_ready        one-cycle completion pulse to the owning core
//   grant             one-hot owner during ACCESS/DONE, 0 in IDLE
//   busy              high during ACCESS and DONE
//   mem_*             shared memory command/response interface
`timescale 1ns/1ps
module shared_mem_arbiter #(
    parameter int MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_read,
    input  logic [3:0]  req_write,
    input  logic [3:0]  req_lock,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [7:0]  resp_rdata,
    output logic [3:0]  resp_ready,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_ready
);

    localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  winner_q, winner_d;
    logic        is_write_q, is_write_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic        lock_flag_q, lock_flag_d;
    logic [7:0]  resp_rdata_q, resp_rdata_d;

    logic [3:0]  requesting;
    logic [7:0]  req_dbl;
    logic [3:0]  req_rot;
    logic [1:0]  rr_offset;
    logic [1:0]  rr_winner;
    logic        lock_hit;
    logic [1:0]  sel_winner;

    assign requesting = req_read | req_write;

    // Rotate the request vector so that bit 0 is the core at rr_ptr; the
    // first set bit of the rotated vector is then the round-robin winner.
    assign req_dbl = {requesting, requesting} >> rr_ptr_q;
    assign req_rot = req_dbl[3:0];

    always_comb begin
        rr_offset = 2'd0;
        if (req_rot[0])      rr_offset = 2'd0;
        else if (req_rot[1]) rr_offset = 2'd1;
        else if (req_rot[2]) rr_offset = 2'd2;
        else if (req_rot[3]) rr_offset = 2'd3;
    end

    assign rr_winner = rr_ptr_q + rr_offset;

    // The lock only re-grants the previous owner while it still requests and
    // has not used up its budget of extra grants.
    assign lock_hit   = lock_flag_q && requesting[winner_q] && (lock_cnt_q < MAX_LOCK_C);
    assign sel_winner = lock_hit ? winner_q : rr_winner;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction and arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_q     <= 2'd0;
            is_write_q   <= 1'b0;
            addr_q       <= 8'd0;
            wdata_q      <= 8'd0;
            rr_ptr_q     <= 2'd0;
            lock_cnt_q   <= 4'd0;
            lock_flag_q  <= 1'b0;
            resp_rdata_q <= 8'd0;
        end else begin
            winner_q     <= winner_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_flag_q  <= lock_flag_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|requesting) state_d = ST_ACCESS;
            ST_ACCESS: if (mem_ready)   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: request latching in IDLE, read capture in ACCESS, lock
    // sampling in DONE.
    always_comb begin
        winner_d     = winner_q;
        is_write_d   = is_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rr_ptr_d     = rr_ptr_q;
        lock_cnt_d   = lock_cnt_q;
        lock_flag_d  = lock_flag_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|requesting) begin
                    winner_d   = sel_winner;
                    is_write_d = req_write[sel_winner];
                    addr_d     = req_addr[{sel_winner, 3'b000} +: 8];
                    wdata_d    = req_wdata[{sel_winner, 3'b000} +: 8];
                    if (lock_hit) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end else begin
                        rr_ptr_d   = rr_winner + 2'd1;
                        lock_cnt_d = 4'd0;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready && !is_write_q) resp_rdata_d = mem_read_data;
            end
            ST_DONE: begin
                lock_flag_d = req_lock[winner_q];
            end
            default: ;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        grant            = 4'd0;
        busy             = 1'b0;
        resp_ready       = 4'd0;
        mem_addr         = 8'd0;
        mem_write_data   = 8'd0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                grant            = 4'b0001 << winner_q;
                busy             = 1'b1;
                mem_addr         = addr_q;
                mem_write_data   = wdata_q;
                mem_read_enable  = !is_write_q;
                mem_write_enable = is_write_q;
            end
            ST_DONE: begin
                grant          = 4'b0001 << winner_q;
                busy           = 1'b1;
                mem_addr       = addr_q;
                mem_write_data = wdata_q;
                resp_ready     = 4'b0001 << winner_q;
            end
            default: ;
        endcase
    end

    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter
// Self-checking bench for shared_mem_arbiter with a behavioural 256-byte
// memory. Expected completions go into a scoreboard queue when a request is
// driven and are popped by a monitor whenever resp_ready pulses.
`timescale 1ns/1ps
module tb_shared_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_read;
   logic [3:0]  req_write;
   logic [3:0]  req_lock;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [7:0]  resp_rdata;
   logic [3:0]  resp_ready;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_write_data;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [7:0]  mem_read_data;
   logic        mem_ready;

   logic [7:0]  mem [0:255];
   logic        mem_clear;
   logic        preload_we;
   logic [7:0]  preload_addr;
   logic [7:0]  preload_data;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] ready;
      logic [7:0] rdata;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      int         core;
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [3:0] exp_grant;
      logic       exp_ren;
      logic       exp_wen;
      logic [7:0] exp_rdata;
   } vec_t;
   vec_t vecs[6];

   logic [3:0] exp_lock_grants [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
   int         exp_cont_times  [4] = '{2, 5, 8, 11};

   shared_mem_arbiter #(.MAX_LOCK(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_read         (req_read),
      .req_write        (req_write),
      .req_lock         (req_lock),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_rdata       (resp_rdata),
      .resp_ready       (resp_ready),
      .grant            (grant),
      .busy             (busy),
      .mem_addr         (mem_addr),
      .mem_write_data   (mem_write_data),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data),
      .mem_ready        (mem_ready)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Behavioural shared memory: combinational read, write on the clock edge
   // when the arbiter commands it and the memory reports completion.
   assign mem_read_data = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
      end else if (preload_we) begin
         mem[preload_addr] <= preload_data;
      end else if (mem_write_enable && mem_ready) begin
         mem[mem_addr] <= mem_write_data;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Scoreboard monitor: every resp_ready pulse must match the oldest
   // outstanding expectation, and must not appear with nothing outstanding.
   always @(negedge clk) begin
      if (resp_ready !== 4'd0) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_resp actual=%0h expected=none at %0t", resp_ready, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("sb_resp_ready", 32'(resp_ready), 32'(e.ready));
            checkOutput("sb_resp_rdata", 32'(resp_rdata), 32'(e.rdata));
         end
      end
   end

   task automatic setReq(input int core, input logic rd, input logic wr, input logic lk,
                         input logic [7:0] addr, input logic [7:0] wdata);
      req_read[core]           = rd;
      req_write[core]          = wr;
      req_lock[core]           = lk;
      req_addr[8*core +: 8]    = addr;
      req_wdata[8*core +: 8]   = wdata;
   endtask

   task automatic clearReqs();
      req_read  = 4'd0;
      req_write = 4'd0;
      req_lock  = 4'd0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_grant"},  32'(grant), 32'd0);
      checkOutput({tag, "_busy"},   32'(busy), 32'd0);
      checkOutput({tag, "_ready"},  32'(resp_ready), 32'd0);
      checkOutput({tag, "_rdata"},  32'(resp_rdata), 32'd0);
      checkOutput({tag, "_ren"},    32'(mem_read_enable), 32'd0);
      checkOutput({tag, "_wen"},    32'(mem_write_enable), 32'd0);
      checkOutput({tag, "_maddr"},  32'(mem_addr), 32'd0);
      checkOutput({tag, "_mwdata"}, 32'(mem_write_data), 32'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      clearReqs();
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
   endtask

   task automatic preload(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      preload_we   = 1'b1;
      preload_addr = addr;
      preload_data = data;
      @(negedge clk);
      preload_we   = 1'b0;
   endtask

   // One single-core transaction: check the ACCESS command, wait for the
   // completion pulse, release the request, and check memory for writes.
   task automatic applyStimulus(input vec_t v);
      bit seen;
      @(negedge clk);
      setReq(v.core, v.rd, v.wr, 1'b0, v.addr, v.wdata);
      sb_q.push_back({v.exp_grant, v.exp_rdata});
      @(negedge clk);
      checkOutput("acc_grant", 32'(grant), 32'(v.exp_grant));
      checkOutput("acc_ren",   32'(mem_read_enable), 32'(v.exp_ren));
      checkOutput("acc_wen",   32'(mem_write_enable), 32'(v.exp_wen));
      checkOutput("acc_maddr", 32'(mem_addr), 32'(v.addr));
      checkOutput("acc_busy",  32'(busy), 32'd1);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (resp_ready !== 4'd0) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL vec_timeout actual=no_resp expected=resp core=%0d", v.core);
      end
      clearReqs();
      @(negedge clk);
      if (v.wr) checkOutput("vec_mem", 32'(mem[v.addr]), 32'(v.wdata));
   endtask

   initial begin
      logic [3:0] gq[$];
      int         tq[$];
      int         resp_cnt;

      mem_clear  = 1'b1;
      preload_we = 1'b0;
      preload_addr = 8'd0;
      preload_data = 8'd0;
      rst = 1'b1;
      clearReqs();
      mem_ready = 1'b1;
      @(negedge clk);
      mem_clear = 1'b0;
      preload(8'h10, 8'h5A);
      preload(8'h33, 8'hC3);

      // core, rd, wr, addr, wdata, grant, ren, wen, rdata
      vecs[0] = '{2, 1'b1, 1'b0, 8'h10, 8'h00, 4'b0100, 1'b1, 1'b0, 8'h5A};
      vecs[1] = '{1, 1'b0, 1'b1, 8'h40, 8'h99, 4'b0010, 1'b0, 1'b1, 8'h5A};
      vecs[2] = '{3, 1'b1, 1'b0, 8'h40, 8'h00, 4'b1000, 1'b1, 1'b0, 8'h99};
      vecs[3] = '{0, 1'b1, 1'b0, 8'h33, 8'h00, 4'b0001, 1'b1, 1'b0, 8'hC3};
      vecs[4] = '{0, 1'b1, 1'b1, 8'h20, 8'h77, 4'b0001, 1'b0, 1'b1, 8'hC3};
      vecs[5] = '{2, 1'b1, 1'b0, 8'h20, 8'h00, 4'b0100, 1'b1, 1'b0, 8'h77};

      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Stall: core3 reads 0x40 with mem_ready low for three ACCESS cycles.
      @(negedge clk);
      setReq(3, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
      mem_ready = 1'b0;
      sb_q.push_back({4'b1000, 8'h99});
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         checkOutput("stall_ren",   32'(mem_read_enable), 32'd1);
         checkOutput("stall_maddr", 32'(mem_addr), 32'h40);
         checkOutput("stall_ready", 32'(resp_ready), 32'd0);
         if (n == 4) mem_ready = 1'b1;
      end
      @(negedge clk);
      checkOutput("stall_resp", 32'(resp_ready), 32'b1000);
      clearReqs();
      @(negedge clk);

      // Contention: four writers from reset release, served 0,1,2,3.
      doReset();
      for (int i = 0; i < 4; i++) begin
         setReq(i, 1'b0, 1'b1, 1'b0, 8'(i), 8'(8'hA0 + i));
         sb_q.push_back({4'(4'b0001 << i), 8'h00});
      end
      gq.delete();
      tq.delete();
      for (int rel = 1; rel <= 30 && tq.size() < 4; rel++) begin
         @(negedge clk);
         if (mem_write_enable || mem_read_enable) gq.push_back(grant);
         if (resp_ready !== 4'd0) begin
            tq.push_back(rel);
            req_write = req_write & ~resp_ready;
         end
      end
      checkOutput("cont_count", 32'(tq.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < tq.size()) checkOutput("cont_time", 32'(tq[i]), 32'(exp_cont_times[i]));
         if (i < gq.size()) checkOutput("cont_grant", 32'(gq[i]), 32'(4'b0001 << i));
      end
      clearReqs();
      @(negedge clk);
      for (int i = 0; i < 4; i++) checkOutput("cont_mem", 32'(mem[i]), 32'(8'hA0 + i));

      // Lock bound: core1 locks continuously, core0 joins after core1's
      // first grant; expect five core1 grants then core0.
      doReset();
      setReq(1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
      for (int i = 0; i < 5; i++) sb_q.push_back({4'b0010, 8'h5A});
      sb_q.push_back({4'b0001, 8'hC3});
      gq.delete();
      resp_cnt = 0;
      for (int n = 0; n < 60 && resp_cnt < 6; n++) begin
         @(negedge clk);
         if (mem_read_enable || mem_write_enable) begin
            gq.push_back(grant);
            setReq(0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00);
         end
         if (resp_ready !== 4'd0) resp_cnt++;
      end
      clearReqs();
      checkOutput("lock_count", 32'(gq.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < gq.size()) checkOutput("lock_grant", 32'(gq[i]), 32'(exp_lock_grants[i]));
      end
      @(negedge clk);
      checkOutput("lock_cnt", 32'(dut.lock_cnt_q), 32'd0);

      // Reset mid-ACCESS during core0's write, then cores 1 and 3 request.
      doReset();
      setReq(0, 1'b0, 1'b1, 1'b0, 8'h50, 8'hEE);
      @(negedge clk);
      checkOutput("rma_wen", 32'(mem_write_enable), 32'd1);
      #2 rst = 1'b1;
      #1 checkAllZero("rma");
      @(negedge clk);
      clearReqs();
      rst = 1'b0;
      checkOutput("rma_mem", 32'(mem[8'h50]), 32'd0);
      setReq(1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      setReq(3, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00);
      sb_q.push_back({4'b0010, 8'h5A});
      sb_q.push_back({4'b1000, 8'hC3});
      gq.delete();
      resp_cnt = 0;
      for (int n = 0; n < 30 && resp_cnt < 2; n++) begin
         @(negedge clk);
         if (mem_read_enable || mem_write_enable) gq.push_back(grant);
         if (resp_ready !== 4'd0) begin
            resp_cnt++;
            req_read = req_read & ~resp_ready;
         end
      end
      clearReqs();
      checkOutput("rma_resps", 32'(resp_cnt), 32'd2);
      if (gq.size() > 0) checkOutput("rma_first_grant", 32'(gq[0]), 32'b0010);
      else checkOutput("rma_first_grant", 32'd0, 32'b0010);
      repeat (3) @(negedge clk);

      checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
